// File: rtl/fop_sweep.sv
// fop_sweep: drives every N-bit vector into an fop evaluator, captures its truth table
// and checks it against EXPECT, reporting pass, mismatch count and first failing vector.
module fop_sweep #(
    parameter int N = 4,
    parameter int SETTLE = 1,
    parameter logic [2**N-1:0] EXPECT = 16'h29AF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    output logic [N-1:0]    fop_in,
    input  logic            fop_out,
    output logic            busy,
    output logic            done,
    output logic [2**N-1:0] table_q,
    output logic            pass,
    output logic [N:0]      mism_cnt,
    output logic [N-1:0]    first_fail
);
    localparam int V = 2**N;
    localparam int CW = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, CHECK, DONE} state_t;

    state_t          state;
    logic [N-1:0]    idx;
    logic [CW-1:0]   cnt;
    logic [V-1:0]    diff;
    logic [N:0]      pop;
    logic [N-1:0]    low;

    // descending scan so the lowest mismatching index is the one left in low
    always_comb begin
        diff = table_q ^ EXPECT;
        pop = '0;
        low = '0;
        for (int i = V - 1; i >= 0; i--) begin
            pop = pop + (N+1)'(diff[i]);
            low = diff[i] ? N'(i) : low;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            fop_in     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            table_q    <= '0;
            pass       <= 1'b0;
            mism_cnt   <= '0;
            first_fail <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state      <= DRIVE;
                        idx        <= '0;
                        cnt        <= '0;
                        fop_in     <= '0;
                        busy       <= 1'b1;
                        table_q    <= '0;
                        pass       <= 1'b0;
                        mism_cnt   <= '0;
                        first_fail <= '0;
                    end
                end
                DRIVE: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == CW'(SETTLE - 1)) begin
                        cnt   <= '0;
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        table_q[idx] <= fop_out;
                        if (&idx) begin
                            state <= CHECK;
                        end else begin
                            idx    <= idx + 1'b1;
                            fop_in <= idx + 1'b1;
                            state  <= DRIVE;
                        end
                    end
                end
                CHECK: begin
                    pass       <= (diff == '0);
                    mism_cnt   <= pop;
                    first_fail <= low;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    state      <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/fop_sweep.md
Name: fop_sweep

Overview:
- Sequential test harness for the 4-bit fop evaluators (gate, dataflow and behavioural variants).
- Upstream side: drives every input vector 0..2^N-1 into the evaluator through fop_in.
- Downstream side: captures the evaluator's 1-bit fop_out per vector into a truth-table register and compares it against an expected pattern.
- Reports pass/fail, the mismatch count and the first failing vector with a start/done handshake, so any evaluator variant can be self-checked in place.

Parameters:
- N, 4, input width of the evaluator; the sweep covers 2^N vectors.
- SETTLE, 1, cycles fop_in is held before sampling; must be >= 1.
- EXPECT, 16'h29AF, expected truth table, 2^N bits; bit i = expected output for input i (minterms 0,1,2,3,5,7,8,11,13).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin sweep; sampled only in IDLE.
- abort  input  1  cancel sweep; sampled in DRIVE/SAMPLE.
- fop_in  output  N  vector driven to the evaluator.
- fop_out  input  1  evaluator result for fop_in.
- busy  output  1  high while sweeping.
- done  output  1  one-cycle pulse when a sweep completes.
- table_q  output  2^N  captured truth table.
- pass  output  1  table_q == EXPECT; valid from done onward.
- mism_cnt  output  N+1  number of bits where table_q differs from EXPECT.
- first_fail  output  N  lowest mismatching index; 0 when pass.

Behaviour:
- Reset (async, rst=1): state=IDLE; fop_in=0, busy=0, done=0, table_q=0, pass=0, mism_cnt=0, first_fail=0; idx and settle counters cleared. Applies immediately, including mid-sweep; no done is issued for the interrupted sweep.
- States: IDLE, DRIVE, SAMPLE, CHECK, DONE.
- IDLE:
  - On start=1, go to DRIVE.
  - Clear idx, table_q, pass, mism_cnt and first_fail.
  - busy=1 from the next cycle.
- DRIVE:
  - fop_in=idx.
  - Settle counter counts SETTLE cycles, then moves to SAMPLE.
- SAMPLE:
  - fop_in is still idx.
  - At the end of this cycle, table_q[idx] <= fop_out.
  - If idx == 2^N-1, go to CHECK; otherwise idx <= idx+1 and return to DRIVE.
- Vector timing: each vector occupies exactly SETTLE+1 cycles, and fop_in is stable for all of them. fop_in changes only on the DRIVE entry edge.
- CHECK (1 cycle):
  - Register pass = (table_q == EXPECT).
  - Register mism_cnt = popcount(table_q ^ EXPECT), width N+1 so that 2^N fits.
  - Register first_fail = index of the lowest set bit of the xor, or 0 if there is none.
- DONE (1 cycle): done=1, busy=0, then return to IDLE.
- Results: table_q, pass, mism_cnt and first_fail hold until the next accepted start or reset.
- Latency: if start is sampled at edge k, done=1 in the cycle following edge k+2^N*(SETTLE+1)+1. That is 34 cycles after accept for N=4, SETTLE=1.
- abort=1 in DRIVE or SAMPLE:
  - Return to IDLE next edge with busy=0 and no done.
  - table_q keeps its partial contents; pass=0.
- Simultaneous events:
  - abort has priority over the SAMPLE capture in the same cycle; the bit is not written.
  - start while busy is ignored.
  - start and abort together in IDLE: start wins, because abort is ignored in IDLE.
  - abort in CHECK or DONE is ignored.
- idx wraps only via the terminal test; it never exceeds 2^N-1.

Test Plan:
- Correct evaluator (fop_G, fop_D or fop_B) attached, SETTLE=1, start pulse: fop_in steps 0..15, each held 2 cycles; done after 34 cycles; table_q=16'h29AF, pass=1, mism_cnt=0, first_fail=0.
- fop_out tied 0: table_q=0, pass=0, mism_cnt=9, first_fail=0.
- Inverted evaluator: table_q=16'hD650, mism_cnt=16, first_fail=0. With fop_out forced 1 only for input 4 (otherwise correct): mism_cnt=1, first_fail=4.
- SETTLE=3, correct evaluator: each vector held 4 cycles, done exactly 66 cycles after accept, single-cycle done pulse; a start pulse during busy changes nothing.
- Abort asserted while fop_in=6, in its SAMPLE cycle: returns to IDLE, no done, table_q bits 0..5 = 6'h2F, bit 6 = 0, pass=0. A following start runs a full clean sweep.
- rst pulsed mid-sweep (fop_in=9) asynchronously: all outputs go to 0 without a clock edge and no done. A subsequent start gives the normal 34-cycle sweep.
